// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. The line is oversampled at CLKS_PER_BIT
// system clocks per bit and each bit is sampled at its midpoint. The stop bit
// is timed but its value is not checked.
module uart_rx #(
   parameter int CLKS_PER_BIT = 54
) (
   input  logic       i_Clock,
   input  logic       i_Reset,
   input  logic       i_Rx_Serial,
   output logic       o_Rx_Done,
   output logic [7:0] o_Rx_Byte
);

   // Counter only needs to reach CLKS_PER_BIT-1.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

   state_t        state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic          rx_meta;
   logic          rx_sync;

   // Two-flop synchronizer; resets to the idle (high) line level so reset
   // release never looks like a start edge.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_Rx_Serial;
         rx_sync <= rx_meta;
      end
   end

   // Frame FSM: find start edge, confirm at mid start bit, then sample each
   // data bit one bit period later, wait to mid stop bit and pulse done.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         o_Rx_Done <= 1'b0;
         o_Rx_Byte <= 8'h00;
      end else begin
         o_Rx_Done <= 1'b0;
         case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (!rx_sync) state <= START;
            end
            START: begin
               if (clk_cnt == HALF_LAST) begin
                  clk_cnt <= '0;
                  // Line went back high before mid start bit: treat as glitch.
                  state   <= rx_sync ? IDLE : DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_cnt != BIT_LAST) begin
                  clk_cnt <= clk_cnt + 1'b1;
               end else begin
                  clk_cnt            <= '0;
                  o_Rx_Byte[bit_idx] <= rx_sync;
                  bit_idx            <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (clk_cnt != BIT_LAST) begin
                  clk_cnt <= clk_cnt + 1'b1;
               end else begin
                  clk_cnt   <= '0;
                  o_Rx_Done <= 1'b1;
                  state     <= CLEANUP;
               end
            end
            CLEANUP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 54 clk/bit, one at 8 clk/bit.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx54 = 1'b1;
   logic       rx8 = 1'b1;
   logic       done54, done8;
   logic [7:0] byte54, byte8;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t0 = 0;
   int lat54 = -1;
   int lat8 = -1;
   int dbl54 = 0;
   int dbl8 = 0;
   logic prev54 = 1'b0;
   logic prev8 = 1'b0;
   logic [7:0] q54[$];
   logic [7:0] q8[$];
   logic [7:0] hello[6];

   uart_rx #(.CLKS_PER_BIT(54)) dut54 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx54),
      .o_Rx_Done(done54), .o_Rx_Byte(byte54)
   );

   uart_rx #(.CLKS_PER_BIT(8)) dut8 (
      .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx8),
      .o_Rx_Done(done8), .o_Rx_Byte(byte8)
   );

   always #5 clk = ~clk;

   // Free-running cycle count for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Collect delivered bytes, first-rise cycle and back-to-back done cycles.
   always @(negedge clk) begin
      if (done54) begin
         q54.push_back(byte54);
         if (!prev54) lat54 <= cyc;
         else dbl54 <= dbl54 + 1;
      end
      if (done8) begin
         q8.push_back(byte8);
         if (!prev8) lat8 <= cyc;
         else dbl8 <= dbl8 + 1;
      end
      prev54 <= done54;
      prev8  <= done8;
   end

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one 10-bit frame starting at a negedge. rb selects a frame bit
   // (0=start, 1..8=data, 9=stop) during which reset is pulsed; -1 for none.
   task automatic send(input logic [7:0] b, input logic stopv, input bit sel8, input int rb);
      int cpb;
      logic [9:0] frame;
      cpb   = sel8 ? 8 : 54;
      frame = {stopv, b, 1'b0};
      t0    = cyc;
      for (int i = 0; i < 10; i++) begin
         if (sel8) rx8 = frame[i];
         else rx54 = frame[i];
         for (int c = 0; c < cpb; c++) begin
            if (i == rb && c == cpb / 2) rst = 1'b1;
            if (i == rb && c == cpb / 2 + 4) rst = 1'b0;
            @(negedge clk);
         end
      end
      rx54 = 1'b1;
      rx8  = 1'b1;
   endtask

   initial begin
      hello[0] = 8'h68; hello[1] = 8'h65; hello[2] = 8'h6C;
      hello[3] = 8'h6C; hello[4] = 8'h6F; hello[5] = 8'h0A;

      // Reset: outputs defined from the first edge with reset high.
      @(negedge clk);
      check("rst_done54", done54, 0);
      check("rst_byte54", byte54, 8'h00);
      check("rst_done8", done8, 0);
      check("rst_byte8", byte8, 8'h00);
      idle(4);
      rst = 1'b0;
      idle(10);

      // Single byte 0x68 at 54 clk/bit; done at 3 + 27 + 9*54 cycles.
      q54.delete();
      send(8'h68, 1'b1, 1'b0, -1);
      idle(100);
      check("b68_count", q54.size(), 1);
      if (q54.size() > 0) check("b68_byte", q54[0], 8'h68);
      check("b68_latency", lat54 - t0, 516);
      check("b68_hold", byte54, 8'h68);

      // "hello\n" back-to-back, no idle gap.
      q54.delete();
      for (int i = 0; i < 6; i++) send(hello[i], 1'b1, 1'b0, -1);
      idle(100);
      check("hello_count", q54.size(), 6);
      for (int i = 0; i < 6 && i < q54.size(); i++) check($sformatf("hello_%0d", i), q54[i], hello[i]);

      // 10-cycle glitch is rejected, next frame still received.
      q54.delete();
      rx54 = 1'b0;
      idle(10);
      rx54 = 1'b1;
      idle(200);
      check("glitch_count", q54.size(), 0);
      send(8'hA5, 1'b1, 1'b0, -1);
      idle(100);
      check("a5_count", q54.size(), 1);
      if (q54.size() > 0) check("a5_byte", q54[0], 8'hA5);

      // All-zero, all-one, and low stop bit (byte still delivered).
      q54.delete();
      send(8'h00, 1'b1, 1'b0, -1);
      send(8'hFF, 1'b1, 1'b0, -1);
      send(8'h55, 1'b0, 1'b0, -1);
      idle(200);
      check("edge_count", q54.size(), 3);
      if (q54.size() > 2) begin
         check("edge_00", q54[0], 8'h00);
         check("edge_ff", q54[1], 8'hFF);
         check("edge_55_lowstop", q54[2], 8'h55);
      end

      // Reset during data bit 4 of 0xFA aborts the frame; the rest of the
      // frame is all high so nothing new starts.
      q54.delete();
      send(8'hFA, 1'b1, 1'b0, 5);
      idle(100);
      check("abort_count", q54.size(), 0);
      check("abort_byte", byte54, 8'h00);
      send(8'h3C, 1'b1, 1'b0, -1);
      idle(100);
      check("3c_count", q54.size(), 1);
      if (q54.size() > 0) check("3c_byte", q54[0], 8'h3C);

      // 8 clk/bit instance: done at 3 + 4 + 9*8 cycles.
      q8.delete();
      send(8'h68, 1'b1, 1'b1, -1);
      idle(40);
      check("c8_count", q8.size(), 1);
      if (q8.size() > 0) check("c8_byte", q8[0], 8'h68);
      check("c8_latency", lat8 - t0, 79);

      // Every done pulse seen was exactly one cycle wide.
      check("pulse_width54", dbl54, 0);
      check("pulse_width8", dbl8, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
